// File: rtl/sha256_compress_core_if.sv
// ---------------------------------------------------------------------------
// sha256_compress_core_if
//   Block-in / digest-out bundle for sha256_compress_core.
//
//   master (block formatter / consumer side):
//     drives  block_valid, block_data[511:0], first_block (, sha224_mode)
//     samples block_ready, busy, digest_valid, digest[255:0]
//   slave (compression core side): the reverse.
//
//   Build option: SHA256_SHA224_EN adds sha224_mode (selects the SHA-224 IV
//   and truncated digest).
// ---------------------------------------------------------------------------
interface sha256_compress_core_if;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         first_block;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;
`ifdef SHA256_SHA224_EN
  logic         sha224_mode;

  modport master (
    output block_valid, block_data, first_block, sha224_mode,
    input  block_ready, busy, digest_valid, digest
  );

  modport slave (
    input  block_valid, block_data, first_block, sha224_mode,
    output block_ready, busy, digest_valid, digest
  );
`else
  modport master (
    output block_valid, block_data, first_block,
    input  block_ready, busy, digest_valid, digest
  );

  modport slave (
    input  block_valid, block_data, first_block,
    output block_ready, busy, digest_valid, digest
  );
`endif
endinterface

// File: rtl/sha256_compress_core.sv
// ---------------------------------------------------------------------------
// sha256_compress_core
//   Sequenced SHA-256 compression engine. Takes one 512-bit block per
//   transfer, expands the message schedule on the fly from a 16-word sliding
//   window, runs UNROLL rounds per clock, then folds the working variables
//   into the chaining value in a single DIGEST cycle.
//
// Parameters:
//   UNROLL        rounds per clock (1, 2, 4 or 8)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   bus (slave)   block_valid/block_ready/block_data/first_block in,
//                 busy/digest_valid/digest out
//
// Build option:
//   SHA256_SHA224_EN  adds bus.sha224_mode: SHA-224 IV and H7 forced to zero
//                     on the digest output. Timing is identical either way.
//
// Timing: the accept edge ends cycle 0, rounds occupy cycles 1..64/UNROLL,
// DIGEST is the next cycle and digest_valid is high from cycle 64/UNROLL+2.
// ---------------------------------------------------------------------------
module sha256_compress_core #(
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  sha256_compress_core_if.slave  bus
);

  localparam int         ROUND_CYCLES = 64 / UNROLL;
  // Counter value at the start of the final ROUNDS cycle.
  localparam logic [5:0] LAST_CTR     = 6'((ROUND_CYCLES - 1) * UNROLL);
  localparam logic [5:0] CTR_STEP     = 6'(UNROLL);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("sha256_compress_core: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA256_SHA224_EN
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  // -------------------------------------------------------------------------
  // SHA-256 logical functions
  // -------------------------------------------------------------------------
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUNDS,
    S_DIGEST,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   h_q  [8];            // chaining value H0..H7
  logic [31:0]   h_d  [8];
  logic [31:0]   wv_q [8];            // working variables a..h
  logic [31:0]   wv_d [8];
  logic [31:0]   w_q  [16];           // w_q[0] is W_t for the current round_ctr
  logic [31:0]   w_d  [16];
  logic [5:0]    ctr_q, ctr_d;
  logic          dv_q, dv_d;
  // Digest is held in its own register so a first_block accept (which
  // reloads H with the IV) does not disturb the previously reported value.
  logic [255:0]  digest_q, digest_d;
`ifdef SHA256_SHA224_EN
  logic          sha224_q, sha224_d;
`endif

  // -------------------------------------------------------------------------
  // Block word unpacking and IV selection
  // -------------------------------------------------------------------------
  logic [31:0] blk_w [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_blk_w
      assign blk_w[gi] = bus.block_data[511 - 32*gi -: 32];
    end
  endgenerate

  logic [31:0] iv_sel [8];

  always_comb begin
    iv_sel = IV256;
`ifdef SHA256_SHA224_EN
    if (bus.sha224_mode) iv_sel = IV224;
`endif
  end

  // -------------------------------------------------------------------------
  // Message schedule: w_ext[0..15] is the live window, w_ext[16..15+UNROLL]
  // are the words generated this cycle. Beyond round 48 these are unused
  // but harmless.
  // -------------------------------------------------------------------------
  logic [31:0] w_ext [16+UNROLL];

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      w_ext[j] = w_q[j];
    end
    for (int j = 16; j < 16 + UNROLL; j++) begin
      w_ext[j] = ssig1(w_ext[j-2]) + w_ext[j-7] + ssig0(w_ext[j-15]) + w_ext[j-16];
    end
  end

  // -------------------------------------------------------------------------
  // UNROLL chained compression rounds
  // -------------------------------------------------------------------------
  logic [31:0] ra, rb, rc, rd, re, rf, rg, rh, rt1, rt2;
  logic [5:0]  kidx;
  logic [31:0] rnd_out [8];

  always_comb begin
    ra = wv_q[0]; rb = wv_q[1]; rc = wv_q[2]; rd = wv_q[3];
    re = wv_q[4]; rf = wv_q[5]; rg = wv_q[6]; rh = wv_q[7];
    rt1  = '0;
    rt2  = '0;
    kidx = ctr_q;
    for (int r = 0; r < UNROLL; r++) begin
      kidx = ctr_q + 6'(r);
      rt1  = rh + bsig1(re) + ch(re, rf, rg) + K_ROM[kidx] + w_ext[r];
      rt2  = bsig0(ra) + maj(ra, rb, rc);
      rh   = rg;
      rg   = rf;
      rf   = re;
      re   = rd + rt1;
      rd   = rc;
      rc   = rb;
      rb   = ra;
      ra   = rt1 + rt2;
    end
    rnd_out[0] = ra; rnd_out[1] = rb; rnd_out[2] = rc; rnd_out[3] = rd;
    rnd_out[4] = re; rnd_out[5] = rf; rnd_out[6] = rg; rnd_out[7] = rh;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic [31:0] h_sum [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
      assign h_sum[gi] = h_q[gi] + wv_q[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    wv_d     = wv_q;
    w_d      = w_q;
    ctr_d    = ctr_q;
    dv_d     = dv_q;
    digest_d = digest_q;
`ifdef SHA256_SHA224_EN
    sha224_d = sha224_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.block_valid) begin
          if (bus.first_block) begin
            h_d  = iv_sel;
            wv_d = iv_sel;
`ifdef SHA256_SHA224_EN
            sha224_d = bus.sha224_mode;
`endif
          end else begin
            wv_d = h_q;
          end
          w_d     = blk_w;
          ctr_d   = '0;
          dv_d    = 1'b0;
          state_d = S_ROUNDS;
        end
      end

      S_ROUNDS: begin
        wv_d = rnd_out;
        for (int j = 0; j < 16; j++) begin
          w_d[j] = w_ext[j + UNROLL];
        end
        if (ctr_q == LAST_CTR) begin
          // Hold the counter so it never leaves 0..63.
          state_d = S_DIGEST;
        end else begin
          ctr_d = ctr_q + CTR_STEP;
        end
      end

      S_DIGEST: begin
        h_d = h_sum;
        for (int i = 0; i < 8; i++) begin
          digest_d[255 - 32*i -: 32] = h_sum[i];
        end
`ifdef SHA256_SHA224_EN
        if (sha224_q) digest_d[31:0] = '0;
`endif
        dv_d    = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      h_q      <= '{default: '0};
      wv_q     <= '{default: '0};
      w_q      <= '{default: '0};
      ctr_q    <= '0;
      dv_q     <= 1'b0;
      digest_q <= '0;
`ifdef SHA256_SHA224_EN
      sha224_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      wv_q     <= wv_d;
      w_q      <= w_d;
      ctr_q    <= ctr_d;
      dv_q     <= dv_d;
      digest_q <= digest_d;
`ifdef SHA256_SHA224_EN
      sha224_q <= sha224_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.block_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.busy         = (state_q == S_ROUNDS) || (state_q == S_DIGEST);
  assign bus.digest_valid = dv_q;
  assign bus.digest       = digest_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_compress_core
//   Directed-vector bench. Four cores (UNROLL = 1, 2, 4, 8) share one clock,
//   reset and stimulus bus; sel routes block_valid to one core and picks which
//   core's outputs are observed. Expected digests are the published SHA-256 /
//   SHA-224 test vectors; expected latency is 64/UNROLL + 2.
// ---------------------------------------------------------------------------
module tb_sha256_compress_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]   sel;
  logic         drv_valid;
  logic         drv_first;
  logic [511:0] drv_data;
`ifdef SHA256_SHA224_EN
  logic         drv_224;
`endif

  sha256_compress_core_if bus [4] ();

  logic         obs_ready [4];
  logic         obs_busy  [4];
  logic         obs_dv    [4];
  logic [255:0] obs_dig   [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      assign bus[gi].block_valid = drv_valid && (sel == gi);
      assign bus[gi].block_data  = drv_data;
      assign bus[gi].first_block = drv_first;
`ifdef SHA256_SHA224_EN
      assign bus[gi].sha224_mode = drv_224;
`endif
      assign obs_ready[gi] = bus[gi].block_ready;
      assign obs_busy[gi]  = bus[gi].busy;
      assign obs_dv[gi]    = bus[gi].digest_valid;
      assign obs_dig[gi]   = bus[gi].digest;

      sha256_compress_core #(.UNROLL(1 << gi)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus[gi])
      );
    end
  endgenerate

  logic         cur_ready, cur_busy, cur_dv;
  logic [255:0] cur_dig;
  assign cur_ready = obs_ready[sel];
  assign cur_busy  = obs_busy[sel];
  assign cur_dv    = obs_dv[sel];
  assign cur_dig   = obs_dig[sel];

  // ---------------------------------------------------------------------------
  // Vectors
  // ---------------------------------------------------------------------------
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_SHA224_EN
  localparam logic [255:0] DIG_224   = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
`endif

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One block, valid dropped after accept; optional stray valid pulse
  // (with different data) at cycle pulse_at during ROUNDS.
  task automatic run_block(input string tag, input logic [1:0] u, input logic [511:0] data,
                           input logic first, input logic [255:0] exp, input int pulse_at);
    int lat;
    bit ctl_ok;
    sel = u;
    @(negedge clk);
    drv_data  = data;
    drv_first = first;
    drv_valid = 1'b1;
    for (int i = 0; i < 200 && !cur_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    lat    = 1;
    ctl_ok = 1'b1;
    while (!cur_dv && lat < 200) begin
      if (cur_ready || !cur_busy) ctl_ok = 1'b0;
      if (lat == pulse_at) begin
        drv_data  = ~data;
        drv_first = 1'b1;
        drv_valid = 1'b1;
      end else begin
        drv_data  = data;
        drv_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    drv_valid = 1'b0;
    check_val({tag, "_lat"}, 256'(lat), 256'((64 >> u) + 2));
    check_val({tag, "_ctl"}, 256'(ctl_ok), 256'(1));
    check_val({tag, "_dig"}, cur_dig, exp);
    $display("[TB] txn %s unroll=%0d lat=%0d digest=%h", tag, 1 << u, lat, cur_dig);
  endtask

  // Two blocks back to back with block_valid held high across the handoff.
  task automatic run_pair(input string tag, input logic [1:0] u);
    int cyc;
    bit ctl_ok;
    sel = u;
    @(negedge clk);
    drv_data  = BLK_TWO1;
    drv_first = 1'b1;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_data  = BLK_TWO2;
    drv_first = 1'b0;
    cyc    = 1;
    ctl_ok = 1'b1;
    while (!cur_ready && cyc < 200) begin
      if (!cur_busy) ctl_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_hand"}, 256'(cyc), 256'((64 >> u) + 2));
    check_val({tag, "_dv1"}, 256'(cur_dv), 256'(1));
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    check_val({tag, "_dvdrop"}, 256'(cur_dv), 256'(0));
    cyc = 1;
    while (!cur_dv && cyc < 200) begin
      if (cur_ready || !cur_busy) ctl_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_lat"}, 256'(cyc), 256'((64 >> u) + 2));
    check_val({tag, "_ctl"}, 256'(ctl_ok), 256'(1));
    check_val({tag, "_dig"}, cur_dig, DIG_TWO);
    $display("[TB] txn %s unroll=%0d lat=%0d digest=%h", tag, 1 << u, cyc, cur_dig);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    sel       = 2'd0;
    drv_valid = 1'b0;
    drv_first = 1'b0;
    drv_data  = '0;
`ifdef SHA256_SHA224_EN
    drv_224   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check_val("rst_ready", 256'(cur_ready), 256'(1));
      check_val("rst_busy",  256'(cur_busy),  256'(0));
      check_val("rst_dv",    256'(cur_dv),    256'(0));
      check_val("rst_dig",   cur_dig,         256'(0));
    end

    run_block("abc_u1",   2'd0, BLK_ABC,   1'b1, DIG_ABC,   -1);
    run_block("empty_u4", 2'd2, BLK_EMPTY, 1'b1, DIG_EMPTY, -1);
    run_pair("two_u2", 2'd1);
    run_pair("two_u8", 2'd3);

    // Reset in the middle of the rounds on the UNROLL=1 core.
    sel = 2'd0;
    @(negedge clk);
    drv_data  = BLK_ABC;
    drv_first = 1'b1;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", 256'(cur_ready), 256'(1));
    check_val("midrst_busy",  256'(cur_busy),  256'(0));
    check_val("midrst_dv",    256'(cur_dv),    256'(0));
    check_val("midrst_dig",   cur_dig,         256'(0));
    reset = 1'b0;
    $display("[TB] txn midrst unroll=1 digest=%h", cur_dig);

    run_block("abc_after_rst", 2'd0, BLK_ABC, 1'b1, DIG_ABC, -1);
    run_block("abc_pulse_u4",  2'd2, BLK_ABC, 1'b1, DIG_ABC, 5);

`ifdef SHA256_SHA224_EN
    drv_224 = 1'b1;
    run_block("sha224_abc", 2'd0, BLK_ABC, 1'b1, DIG_224, -1);
    drv_224 = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=hang exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_compress_core.md
Name: sha256_compress_core

Overview:
- Self-contained, parametrised SHA-256 compression engine.
- Accepts one 512-bit message block per transaction and computes the message schedule on the fly with a 16-word sliding window.
- Each cycle it runs UNROLL compression rounds, then folds the working variables into the chaining digest.
- Sits between the padding/block-formatter and the hash-output interface. It replaces the separate combinational round/digest-update logic with one sequenced core.

Parameters:
- UNROLL, 1: rounds per clock. Legal values 1, 2, 4, 8; any other value raises an elaboration-time error.
- ROUND_CYCLES, 64/UNROLL: derived localparam, not overridable. Number of ROUNDS-state cycles.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- block_valid  input  1  block_data/first_block valid
- block_ready  output  1  core can accept a block this cycle
- block_data  input  512  message block; [511:480]=W0 … [31:0]=W15, big-endian words
- first_block  input  1  sampled with block; 1 = start a new message from the IV
- busy  output  1  compression in progress
- digest_valid  output  1  digest holds the result of the last accepted block
- digest  output  256  [255:224]=H0 … [31:0]=H7

Behaviour:
- Reset: state IDLE; H0..H7, a..h, W window, round_ctr all 0. Outputs: block_ready=1, busy=0, digest_valid=0, digest=0.
- States and transitions:
  - IDLE / DONE: block_ready=1. A transfer occurs when block_valid & block_ready.
    - If first_block=1: H loads the FIPS 180-4 IV (6a09e667 … 5be0cd19), and a..h load the same IV.
    - If first_block=0: a..h load the current H.
    - On transfer: W window loads block_data, round_ctr=0, digest_valid clears, next state ROUNDS.
  - ROUNDS: block_ready=0, busy=1. Each cycle performs UNROLL chained rounds t=round_ctr..round_ctr+UNROLL-1.
    - W_t comes from the window for t<16; otherwise W_t = σ1(W_t-2) + W_t-7 + σ0(W_t-15) + W_t-16.
    - The window shifts by UNROLL words per cycle.
    - K_t comes from an internal 64-entry constant ROM.
    - T1 = h+Σ1(e)+Ch(e,f,g)+K_t+W_t; T2 = Σ0(a)+Maj(a,b,c); a'=T1+T2; e'=d+T1; the rest shift down.
    - round_ctr += UNROLL. When round_ctr reaches 64-UNROLL this cycle, next state DIGEST.
  - DIGEST: busy=1, block_ready=0. Hi <= Hi + working variable i (mod 2^32), one cycle. Next state DONE with digest_valid=1.
- Arithmetic: all additions are mod 2^32; carries are discarded.
- Latency: the accept edge is cycle 0. digest_valid rises at cycle ROUND_CYCLES+2 (66 for UNROLL=1, 10 for UNROLL=8).
- Throughput: one block per ROUND_CYCLES+2 cycles. A new block may be accepted in the same cycle digest_valid is high. digest_valid drops the cycle after that accept.
- digest is stable while digest_valid=1 and until the next accepted block's DIGEST cycle.
- Boundary conditions:
  - block_valid during ROUNDS or DIGEST: ignored, no stall of the core; the source must hold the block.
  - first_block=0 as the very first block after reset: chains from H=0. This is defined and deterministic, but not a valid SHA-256 use.
  - reset asserted mid-ROUNDS or mid-DIGEST: the next edge forces the full reset state. A partial digest is never flagged valid.
  - round_ctr never exceeds 63; the ROM index wraps only by state exit.

Optional Feature:
- SHA256_SHA224_EN
- Defined:
  - Adds input port sha224_mode (1 bit), sampled with first_block=1 and held for the message.
  - When 1, the IV is the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - When 1, digest[31:0] (H7) is forced to 0; the consumer takes digest[255:32].
- Undefined: no port; SHA-256 IV only; full 256-bit digest. Cycle timing is identical in both builds.

Test Plan:
- "abc", one padded block, first_block=1, UNROLL=1 -> digest_valid at cycle 66; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message, one block (80000000, then zeros), UNROLL=4 -> digest_valid at cycle 18; digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first_block=1, then 0), back-to-back with block_valid held high, UNROLL=2 and UNROLL=8 -> final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; block_ready low throughout ROUNDS and DIGEST.
- Reset pulsed at round 30 of a block -> next cycle block_ready=1, busy=0, digest_valid=0, digest=0. Re-running "abc" afterwards gives the correct hash.
- With SHA256_SHA224_EN, sha224_mode=1, "abc" -> digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; digest[31:0]=0.
- block_valid pulsed during ROUNDS -> no transfer, and the in-flight digest is unchanged versus the golden model.
